b_write_arbiter: RTL and testbench
==================================

Name: b_write_arbiter

Overview:
- Round-robin arbiter that shares the 16-bit B register between five write requesters (B mux sources 0..4, a..e) and a clear request (mux source 5, constant zero).
- Drives the B-system select and write-enable lines (b_src, b_write) and returns a one-cycle acknowledge to the winning requester.
- Sits between the multicycle control unit and the B register/mux pair. The control unit can block new grants with stall while it is reading B.

Parameters:
- NREQ, 5, number of data requesters; fixed by the B mux width and must not be overridden.
- CLR_SRC, 3'd5, b_src code used for a clear (the zero input of the B mux).
- PTR_RST, 3'd4, round-robin pointer value after reset, so that requester 0 has first priority.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  5  req[i]=1 means requester i wants B loaded from mux input i; held until ack[i].
- clr_req  input  1  request to load B with zero; held until clr_ack.
- stall  input  1  while 1, no new grant is issued from IDLE.
- b_src  output  3  B mux select, registered.
- b_write  output  1  B register write enable, registered.
- ack  output  5  one-hot acknowledge; ack[i]=1 for exactly one cycle after B holds requester i's value.
- clr_ack  output  1  acknowledge for clr_req, same timing as ack.
- busy  output  1  1 in the WRITE and ACK states.
- grant_count  output  16  number of completed grants (data and clear), wrapping.

Behaviour:
- Reset (async, immediate): state=IDLE, b_src=0, b_write=0, ack=0, clr_ack=0, busy=0, grant_count=0, ptr=PTR_RST.
- States:
  - IDLE: if stall=0 and any request is pending, pick a winner, register b_src=winner code and b_write=1, go to WRITE. Otherwise stay; b_write=0.
  - WRITE: b_write=1 for exactly this one cycle. B captures the selected input at the closing edge. At that edge: b_write←0, ack[winner] (or clr_ack)←1, ptr←winner (data winners only), go to ACK.
  - ACK: acknowledge high for exactly one cycle. grant_count increments at the closing edge (16-bit wrap, 0xFFFF→0x0000). Go to IDLE.
- Latency: request first seen at edge k → b_write high in cycle k+1 → ack high in cycle k+2. A back-to-back grant is possible 3 cycles apart, minimum.
- Winner selection, evaluated in IDLE only:
  - clr_req has absolute priority over all data requests.
  - Otherwise the first set req[i] is chosen, scanning i = ptr+1, ptr+2, … modulo 5.
  - ptr holds values 0..4. Wrap from 4 goes to 0.
  - A clear grant does not move ptr.
- Requests arriving in WRITE or ACK are not sampled until IDLE. Requests are never lost while held.
- A requester deasserts req in its ack cycle. If it is still high in IDLE it is treated as a new request.
- A request dropped before its grant is simply not served. A request dropped during WRITE does not cancel it: the write and ack complete.
- stall affects only the IDLE→WRITE decision. A grant already in WRITE or ACK completes. stall=1 with pending requests holds IDLE indefinitely, with no b_write.
- busy = (state==WRITE)||(state==ACK), registered together with the state.
- Reset asserted in WRITE drops b_write the same instant, with no ack. The B register shares this reset, so no partial value remains.
- Outputs are glitch-free: b_src and b_write come directly from flops. The decision logic is combinational but is registered into b_src.
- b_src is held at its last value outside WRITE. It is don't-care whenever b_write=0.

Decomposition:
- Shared package (header of `define constants):
  - source codes SRC_A..SRC_E = 0..4 and SRC_ZERO = 5;
  - state encodings ST_IDLE=2'd0, ST_WRITE=2'd1, ST_ACK=2'd2.
  The same codes are used by the control unit and the B mux.
- One sub-module, rr_pick5: a combinational rotating priority encoder with inputs req[4:0] and ptr[2:0] and outputs valid and idx[2:0]. Reusable for arbiters on the other datapath registers.

Test Plan:
- Reset, then req=5'b00001 → b_write=1 with b_src=0 in cycle 1, ack=5'b00001 in cycle 2, grant_count=1 afterwards, B=input a.
- req=5'b11111 held, each requester dropping its bit on its ack → grant order 0,1,2,3,4. Grants are 3 cycles apart, grant_count=5.
- clr_req=1 and req=5'b00100 together → clear first (b_src=5, clr_ack, B=0x0000), then requester 2. ptr is unchanged by the clear.
- stall=1 with req=5'b00010 for 4 cycles → b_write stays 0. stall=0 → b_write in the next cycle with b_src=1.
- reset pulsed while in WRITE → b_write=0 immediately, no ack, state IDLE, grant_count=0.
- grant_count preloaded to 0xFFFF by forcing 65535 grants (or via a bench force) → next completed grant gives 0x0000.

Source files
------------

// File: rtl/b_write_arbiter_pkg.sv
// b_write_arbiter_pkg: B-system source codes, arbiter state encoding and sizing constants.
// Shared by the control unit, the B mux and the register write arbiters.
package b_write_arbiter_pkg;
    localparam int NREQ = 5;
    localparam logic [2:0] SRC_A    = 3'd0;
    localparam logic [2:0] SRC_B    = 3'd1;
    localparam logic [2:0] SRC_C    = 3'd2;
    localparam logic [2:0] SRC_D    = 3'd3;
    localparam logic [2:0] SRC_E    = 3'd4;
    localparam logic [2:0] SRC_ZERO = 3'd5;
    localparam logic [2:0] CLR_SRC  = SRC_ZERO;
    // Pointer starts at the last requester so the first scan begins at requester 0.
    localparam logic [2:0] PTR_RST  = SRC_E;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_ACK   = 2'd2
    } state_t;
endpackage

// File: rtl/b_write_arbiter_rr_pick5.sv
// rr_pick5: combinational rotating priority encoder over five requests.
// Ports: req[4:0] requests, ptr[2:0] last winner (0..4);
//        valid any request set, idx[2:0] first set request after ptr (mod 5).
module rr_pick5
    import b_write_arbiter_pkg::*;
(
    input  logic [4:0] req,
    input  logic [2:0] ptr,
    output logic       valid,
    output logic [2:0] idx
);
    logic [2:0] j;
    // Scan from farthest to nearest so the position closest after ptr wins.
    always_comb begin
        valid = |req;
        idx   = SRC_A;
        j     = SRC_A;
        for (int k = NREQ; k >= 1; k--) begin
            j = 3'((int'(ptr) + k) % NREQ);
            if (req[j]) idx = j;
        end
    end
endmodule

// File: rtl/b_write_arbiter.sv
// b_write_arbiter: round-robin arbiter granting the 16-bit B register to five writers or a clear.
// Ports: CLK, reset (async, active-high); req[4:0]/clr_req held until acknowledged;
//        stall blocks new grants; b_src/b_write drive the B mux and register;
//        ack[4:0]/clr_ack one-cycle acknowledge; busy in WRITE/ACK; grant_count completed grants.
module b_write_arbiter
    import b_write_arbiter_pkg::*;
(
    input  logic        CLK,
    input  logic        reset,
    input  logic [4:0]  req,
    input  logic        clr_req,
    input  logic        stall,
    output logic [2:0]  b_src,
    output logic        b_write,
    output logic [4:0]  ack,
    output logic        clr_ack,
    output logic        busy,
    output logic [15:0] grant_count
);
    state_t      state_q, state_d;
    logic [2:0]  ptr_q, ptr_d;
    logic [2:0]  src_q, src_d;
    logic        write_q, write_d;
    logic [4:0]  ack_q, ack_d;
    logic        clr_ack_q, clr_ack_d;
    logic        busy_q, busy_d;
    logic [15:0] grant_count_q, grant_count_d;
    logic        pick_valid;
    logic [2:0]  pick_idx;

    rr_pick5 u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // src_q doubles as the winner record while in WRITE.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        src_d         = src_q;
        write_d       = 1'b0;
        ack_d         = '0;
        clr_ack_d     = 1'b0;
        grant_count_d = grant_count_q;
        case (state_q)
            ST_IDLE: begin
                if (!stall && (clr_req || pick_valid)) begin
                    state_d = ST_WRITE;
                    src_d   = clr_req ? CLR_SRC : pick_idx;
                    write_d = 1'b1;
                end
            end
            ST_WRITE: begin
                state_d = ST_ACK;
                if (src_q == CLR_SRC) begin
                    clr_ack_d = 1'b1;
                end else begin
                    ack_d = 5'b00001 << src_q;
                    ptr_d = src_q;
                end
            end
            ST_ACK: begin
                state_d       = ST_IDLE;
                grant_count_d = grant_count_q + 16'd1;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = state_d != ST_IDLE;
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            ptr_q         <= PTR_RST;
            src_q         <= SRC_A;
            write_q       <= 1'b0;
            ack_q         <= '0;
            clr_ack_q     <= 1'b0;
            busy_q        <= 1'b0;
            grant_count_q <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            src_q         <= src_d;
            write_q       <= write_d;
            ack_q         <= ack_d;
            clr_ack_q     <= clr_ack_d;
            busy_q        <= busy_d;
            grant_count_q <= grant_count_d;
        end
    end

    assign b_src       = src_q;
    assign b_write     = write_q;
    assign ack         = ack_q;
    assign clr_ack     = clr_ack_q;
    assign busy        = busy_q;
    assign grant_count = grant_count_q;
endmodule

// File: tb/tb_b_write_arbiter.sv
// tb_b_write_arbiter: directed table, corner sequences and randomized checks of b_write_arbiter.
module tb_b_write_arbiter;
    logic        CLK = 1'b0;
    logic        reset;
    logic [4:0]  req;
    logic        clr_req;
    logic        stall;
    logic [2:0]  b_src;
    logic        b_write;
    logic [4:0]  ack;
    logic        clr_ack;
    logic        busy;
    logic [15:0] grant_count;

    int n_tests = 0;
    int n_fail  = 0;

    b_write_arbiter dut (
        .CLK         (CLK),
        .reset       (reset),
        .req         (req),
        .clr_req     (clr_req),
        .stall       (stall),
        .b_src       (b_src),
        .b_write     (b_write),
        .ack         (ack),
        .clr_ack     (clr_ack),
        .busy        (busy),
        .grant_count (grant_count)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    typedef struct {
        logic [4:0]  req;
        logic        clr;
        logic        stall;
        logic        bw;
        logic [2:0]  src;
        logic [4:0]  ack;
        logic        cack;
        logic        busy;
        logic [15:0] cnt;
    } vec_t;

    vec_t vt[16];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        reset   = 1'b1;
        req     = '0;
        clr_req = 1'b0;
        stall   = 1'b0;
        @(negedge CLK);
        reset = 1'b0;
    endtask

    // Reference rule: first set request scanning last+1, last+2, ... modulo 5.
    function automatic int pick(input logic [4:0] r, input int last);
        for (int k = 1; k <= 5; k++)
            if (r[(last + k) % 5]) return (last + k) % 5;
        return -1;
    endfunction

    int m_phase, m_win, m_last;
    logic [15:0] m_cnt;
    logic [4:0]  m_ack;
    int got[$];
    int last_t;

    initial begin
        vt[0]  = '{5'b00001, 1'b0, 1'b0, 1'b1, 3'd0, 5'b00000, 1'b0, 1'b1, 16'd0};
        vt[1]  = '{5'b00001, 1'b0, 1'b0, 1'b0, 3'd0, 5'b00001, 1'b0, 1'b1, 16'd0};
        vt[2]  = '{5'b00000, 1'b0, 1'b0, 1'b0, 3'd0, 5'b00000, 1'b0, 1'b0, 16'd1};
        vt[3]  = '{5'b00100, 1'b1, 1'b0, 1'b1, 3'd5, 5'b00000, 1'b0, 1'b1, 16'd1};
        vt[4]  = '{5'b00100, 1'b1, 1'b0, 1'b0, 3'd0, 5'b00000, 1'b1, 1'b1, 16'd1};
        vt[5]  = '{5'b00100, 1'b0, 1'b0, 1'b0, 3'd0, 5'b00000, 1'b0, 1'b0, 16'd2};
        vt[6]  = '{5'b00100, 1'b0, 1'b0, 1'b1, 3'd2, 5'b00000, 1'b0, 1'b1, 16'd2};
        vt[7]  = '{5'b00100, 1'b0, 1'b0, 1'b0, 3'd0, 5'b00100, 1'b0, 1'b1, 16'd2};
        vt[8]  = '{5'b00000, 1'b0, 1'b0, 1'b0, 3'd0, 5'b00000, 1'b0, 1'b0, 16'd3};
        vt[9]  = '{5'b00010, 1'b0, 1'b1, 1'b0, 3'd0, 5'b00000, 1'b0, 1'b0, 16'd3};
        vt[10] = '{5'b00010, 1'b0, 1'b1, 1'b0, 3'd0, 5'b00000, 1'b0, 1'b0, 16'd3};
        vt[11] = '{5'b00010, 1'b0, 1'b1, 1'b0, 3'd0, 5'b00000, 1'b0, 1'b0, 16'd3};
        vt[12] = '{5'b00010, 1'b0, 1'b1, 1'b0, 3'd0, 5'b00000, 1'b0, 1'b0, 16'd3};
        vt[13] = '{5'b00010, 1'b0, 1'b0, 1'b1, 3'd1, 5'b00000, 1'b0, 1'b1, 16'd3};
        vt[14] = '{5'b00010, 1'b0, 1'b0, 1'b0, 3'd0, 5'b00010, 1'b0, 1'b1, 16'd3};
        vt[15] = '{5'b00000, 1'b0, 1'b0, 1'b0, 3'd0, 5'b00000, 1'b0, 1'b0, 16'd4};

        reset = 1'b1; req = '0; clr_req = 1'b0; stall = 1'b0;
        #12;
        chk("rst_b_write", b_write, 0);
        chk("rst_b_src", b_src, 0);
        chk("rst_ack", ack, 0);
        chk("rst_clr_ack", clr_ack, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count", grant_count, 0);
        @(negedge CLK);
        reset = 1'b0;

        // Directed table: single grant, clear priority, stall hold.
        for (int i = 0; i < 16; i++) begin
            req = vt[i].req; clr_req = vt[i].clr; stall = vt[i].stall;
            @(negedge CLK);
            chk($sformatf("tbl%0d_b_write", i), b_write, vt[i].bw);
            if (vt[i].bw) chk($sformatf("tbl%0d_b_src", i), b_src, vt[i].src);
            chk($sformatf("tbl%0d_ack", i), ack, vt[i].ack);
            chk($sformatf("tbl%0d_clr_ack", i), clr_ack, vt[i].cack);
            chk($sformatf("tbl%0d_busy", i), busy, vt[i].busy);
            chk($sformatf("tbl%0d_count", i), grant_count, vt[i].cnt);
        end

        // Round robin with all five requesters held, each dropping on its ack.
        do_reset();
        req = 5'b11111;
        last_t = -1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge CLK);
            if (ack != 0) begin
                for (int i = 0; i < 5; i++) if (ack[i]) got.push_back(i);
                if (last_t >= 0) chk("rr_gap", 16'(cyc - last_t), 3);
                last_t = cyc;
                req = req & ~ack;
            end
            if (got.size() == 5) break;
        end
        chk("rr_grants", 16'(got.size()), 5);
        for (int i = 0; i < got.size(); i++) chk($sformatf("rr_order%0d", i), 16'(got[i]), 16'(i));
        @(negedge CLK);
        chk("rr_count", grant_count, 5);

        // Reset pulsed during WRITE.
        do_reset();
        req = 5'b00001;
        @(negedge CLK);
        chk("rw_b_write_pre", b_write, 1);
        #2 reset = 1'b1;
        #1;
        chk("rw_b_write", b_write, 0);
        chk("rw_busy", busy, 0);
        chk("rw_ack", ack, 0);
        req = '0;
        @(negedge CLK);
        reset = 1'b0;
        @(negedge CLK);
        chk("rw_ack_after", ack, 0);
        chk("rw_count", grant_count, 0);
        chk("rw_busy_after", busy, 0);

        // Grant counter wrap from 0xFFFF.
        do_reset();
        force dut.grant_count_q = 16'hFFFF;
        #1 release dut.grant_count_q;
        #1 chk("wrap_pre", grant_count, 16'hFFFF);
        req = 5'b01000;
        @(negedge CLK);
        chk("wrap_b_src", b_src, 3);
        @(negedge CLK);
        chk("wrap_ack", ack, 5'b01000);
        req = '0;
        @(negedge CLK);
        chk("wrap_count", grant_count, 16'h0000);

        // Randomized traffic against a transaction-level reference.
        do_reset();
        m_phase = 0; m_win = 0; m_last = 4; m_cnt = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            m_ack = (m_phase == 2 && m_win < 5) ? 5'(1 << m_win) : 5'b0;
            chk("rnd_b_write", b_write, 16'(m_phase == 1));
            if (m_phase == 1) chk("rnd_b_src", b_src, 16'(m_win));
            chk("rnd_ack", ack, m_ack);
            chk("rnd_clr_ack", clr_ack, 16'(m_phase == 2 && m_win == 5));
            chk("rnd_busy", busy, 16'(m_phase != 0));
            chk("rnd_count", grant_count, m_cnt);
            req = req & ~m_ack;
            if (m_phase == 2 && m_win == 5) clr_req = 1'b0;
            for (int i = 0; i < 5; i++) begin
                if (!req[i] && $urandom_range(0, 7) == 0) req[i] = 1'b1;
                else if (req[i] && $urandom_range(0, 31) == 0) req[i] = 1'b0;
            end
            if (!clr_req && $urandom_range(0, 15) == 0) clr_req = 1'b1;
            stall = ($urandom_range(0, 3) == 0);
            if (m_phase == 0) begin
                if (!stall && (clr_req || req != 0)) begin
                    m_win = clr_req ? 5 : pick(req, m_last);
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                m_phase = 2;
                if (m_win < 5) m_last = m_win;
            end else begin
                m_phase = 0;
                m_cnt = m_cnt + 16'd1;
            end
            @(negedge CLK);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
